// File: rtl/replay_fifo.sv
// Synchronous FIFO with a replay window: reads advance r_ptr, but space is only
// reclaimed when the consumer commits with mark; rewind re-sends from the mark.
module replay_fifo #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              mark,
  input  logic              rewind,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   held,
  output logic              overflow,
  output logic              underflow
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [PW-1:0] DEPTH_V  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_V  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_V = PW'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0]     w_ptr_q, w_ptr_d;
  logic [PW-1:0]     r_ptr_q, r_ptr_d;
  logic [PW-1:0]     m_ptr_q, m_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              rewind_eff;
  logic              wr_acc;
  logic              rd_acc;

  // Status decodes purely from the registered pointers.
  always_comb begin
    count        = w_ptr_q - r_ptr_q;
    held         = w_ptr_q - m_ptr_q;
    full         = (held == DEPTH_V);
    empty        = (count == '0);
    almost_full  = (held >= AFULL_V);
    almost_empty = (count <= AEMPTY_V);
  end

  // mark beats rewind; an effective rewind swallows any same-cycle read.
  always_comb begin
    rewind_eff = rewind && !mark;
    wr_acc     = wr_en && !full;
    rd_acc     = rd_en && !empty && !rewind_eff;
  end

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    m_ptr_d     = m_ptr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc)
      w_ptr_d = w_ptr_q + PW'(1);
    if (wr_en && full)
      overflow_d = 1'b1;

    if (rd_acc) begin
      rd_data_d  = mem[r_ptr_q[ADDR_W-1:0]];
      rd_valid_d = 1'b1;
      r_ptr_d    = r_ptr_q + PW'(1);
    end
    if (rd_en && empty && !rewind_eff)
      underflow_d = 1'b1;

    // Pre-cycle r_ptr: a word read in this same cycle remains held.
    if (mark)
      m_ptr_d = r_ptr_q;
    else if (rewind_eff)
      r_ptr_d = m_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      m_ptr_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      m_ptr_q     <= m_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc)
      mem[w_ptr_q[ADDR_W-1:0]] <= wr_data;
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: doc/replay_fifo.md
# replay_fifo

Parametrised synchronous FIFO with internal storage and a replay window, the next generation of our 4-bit-pointer FIFO controller. Read entries are not freed until the consumer commits them with `mark`. `rewind` restores the read pointer to the last mark so un-acknowledged data can be re-sent. It sits between a packet producer and a link transmitter in the replay-buffer datapath.

## Interface
- `DATA_W`, default 8: data word width.
- `ADDR_W`, default 4: address width; DEPTH = 2**ADDR_W entries.
- `AFULL_TH`, default 12: `almost_full` asserts when held >= AFULL_TH.
- `AEMPTY_TH`, default 2: `almost_empty` asserts when count <= AEMPTY_TH.
- `clk`  in  1  clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `wr_en`  in  1  write request.
- `wr_data`  in  DATA_W  write data.
- `rd_en`  in  1  read request.
- `rd_data`  out  DATA_W  registered read data.
- `rd_valid`  out  1  `rd_data` holds a newly read word this cycle.
- `mark`  in  1  commit: free every entry before the current read pointer.
- `rewind`  in  1  replay: restore the read pointer to the mark pointer.
- `full`, `empty`  out  1  status flags.
- `almost_full`, `almost_empty`  out  1  threshold flags.
- `count`  out  ADDR_W+1  readable entries (w_ptr - r_ptr).
- `held`  out  ADDR_W+1  occupied entries (w_ptr - m_ptr).
- `overflow`, `underflow`  out  1  sticky error flags.

## Operation
- Three pointers, each ADDR_W+1 bits: `w_ptr`, `r_ptr`, `m_ptr`.
  - The MSB is the wrap bit; the low ADDR_W bits address the memory.
  - All arithmetic is modulo 2**(ADDR_W+1).
  - Invariant: m_ptr <= r_ptr <= w_ptr, in modular distance.
- `full` = (held == DEPTH). `empty` = (count == 0). Both decode combinationally from registered pointers.
- Write is accepted when wr_en && !full.
  - mem[w_ptr] <= wr_data; w_ptr++.
  - When wr_en && full, the write is dropped and `overflow` <= 1.
- Read is accepted when rd_en && !empty && !rewind.
  - rd_data <= mem[r_ptr]; r_ptr++; rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data holds its value.
  - When rd_en && empty && !rewind, `underflow` <= 1.
- `mark`: m_ptr <= r_ptr, using the pre-cycle value, so a read in the same cycle stays held.
- `rewind` (only when !mark): r_ptr <= m_ptr. Any same-cycle read is suppressed and raises no flag.
- `mark` and `rewind` together: `mark` wins and `rewind` is ignored.
- Simultaneous write and accepted read are both performed. Full and empty are judged on pre-cycle pointers, so:
  - A write while full is dropped even if mark or read frees space in the same cycle.
  - A read while empty is rejected even with a same-cycle write.
- A rewind in the same cycle as a write still accepts the write.
- `overflow` and `underflow` clear only on reset.
- Memory contents are not reset.

## Timing
- Reset values:
  - w_ptr = r_ptr = m_ptr = 0, rd_data = 0, rd_valid = 0.
  - full = 0, empty = 1, count = 0, held = 0.
  - almost_full = 0, almost_empty = 1, overflow = 0, underflow = 0.
- Reset asserted mid-operation discards all content and replay state on that edge. It takes priority over every request.
- Write to read: a word written at edge N makes `empty` deassert after N and can be read at edge N+1.
- Read latency: one cycle. rd_en accepted at edge N means rd_data/rd_valid are valid after N.
- Status flags and count/held reflect the pointers updated at the previous edge. No flag is registered separately.
- Pointer wrap: after 2**(ADDR_W+1) accepted operations the pointer returns to 0 with no disturbance to flags.

## Test plan
- Reset, then 16 writes (0x00..0x0F), no reads -> full=1 and held=16 after the 16th; a 17th write is dropped and overflow=1.
- Fill 16, then read 16 -> rd_data 0x00..0x0F with one-cycle latency; count=0 and empty=1, but held=16 and full stays 1 (no mark). Then mark -> held=0 and full=0 the next cycle.
- Write 0xA1..0xA4; read 2; rewind; read 4 -> output sequence A1, A2, A1, A2, A3, A4. The rd_en asserted with rewind produces rd_valid=0.
- Write 3; read 3 with mark asserted during the 3rd read, then rewind -> replayed word is only the 3rd word (mark captured the pre-read pointer).
- rd_en on empty with a same-cycle wr_en -> read rejected and underflow=1; the write is accepted and count=1 the next cycle.
- 40 write/read/mark cycles (pointer wrap past 31) -> data order preserved and no spurious full or empty. Then assert reset mid-stream -> all outputs return to reset values on the next edge.
